// File: rtl/pipe_ctrl.sv
// pipe_ctrl: load-use, jump and mul/div hazard controller for the riscx in-order core.
// Optional perf counters are built when RISCX_PERF_CNT_EN is defined.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
module pipe_ctrl #(
  parameter int PC_WIDTH     = `PC_WIDTH,
  parameter int MDIV_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_rs1_ren_i,
  input  logic                id_rs2_ren_i,
  input  logic [4:0]          id_rs1_raddr_i,
  input  logic [4:0]          id_rs2_raddr_i,
  input  logic                ex_load_i,
  input  logic                ex_rd_wen_i,
  input  logic [4:0]          ex_rd_waddr_i,
  input  logic                ex_jump_i,
  input  logic [PC_WIDTH-1:0] ex_jump_addr_i,
  input  logic                ex_mdiv_start_i,
  input  logic                mdiv_done_i,
  output logic                pc_stall_o,
  output logic                if_id_stall_o,
  output logic                if_id_flush_o,
  output logic                id_ex_stall_o,
  output logic                id_ex_flush_o,
  output logic                pc_redirect_o,
  output logic [PC_WIDTH-1:0] pc_redirect_addr_o,
  output logic                mdiv_err_o,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
);
  typedef enum logic {RUN, MDIV_WAIT} state_t;
  state_t     r_state, w_next;
  logic [7:0] r_wdog, w_wdog_next;
  logic       r_err, w_err_next;
  logic       w_lu, w_pc_stall, w_id_ex_stall, w_flush, w_id_ex_flush, w_redirect;
  assign w_lu = ex_load_i & ex_rd_wen_i & (ex_rd_waddr_i != 5'd0) &
                ((id_rs1_ren_i & (id_rs1_raddr_i == ex_rd_waddr_i)) |
                 (id_rs2_ren_i & (id_rs2_raddr_i == ex_rd_waddr_i)));
  always_comb begin
    w_next        = r_state;
    w_wdog_next   = r_wdog;
    w_err_next    = 1'b0;
    w_pc_stall    = 1'b0;
    w_id_ex_stall = 1'b0;
    w_flush       = 1'b0;
    w_id_ex_flush = 1'b0;
    w_redirect    = 1'b0;
    if (r_state == RUN) begin
      if (ex_jump_i) begin
        w_redirect    = 1'b1;
        w_flush       = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if (ex_mdiv_start_i) begin
        w_pc_stall    = 1'b1;
        w_id_ex_stall = 1'b1;
        w_wdog_next   = 8'(MDIV_TIMEOUT - 1);
        w_next        = MDIV_WAIT;
      end else if (w_lu) begin
        w_pc_stall    = 1'b1;
        w_id_ex_flush = 1'b1;
      end
    end else if (mdiv_done_i) begin
      w_next = RUN;
    end else if (r_wdog == 8'd0) begin
      w_err_next = 1'b1;
      w_next     = RUN;
    end else begin
      w_pc_stall    = 1'b1;
      w_id_ex_stall = 1'b1;
      w_wdog_next   = r_wdog - 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_wdog  <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wdog  <= w_wdog_next;
      r_err   <= w_err_next;
    end
  end
  assign pc_stall_o         = rst_n & w_pc_stall;
  assign if_id_stall_o      = rst_n & w_pc_stall;
  assign if_id_flush_o      = rst_n & w_flush;
  assign id_ex_stall_o      = rst_n & w_id_ex_stall;
  assign id_ex_flush_o      = rst_n & w_id_ex_flush;
  assign pc_redirect_o      = rst_n & w_redirect;
  assign pc_redirect_addr_o = (rst_n & w_redirect) ? ex_jump_addr_i : '0;
  assign mdiv_err_o         = rst_n & r_err;
`ifdef RISCX_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pc_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_redirect && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end
  assign stall_cnt_o = rst_n ? r_stall_cnt : '0;
  assign flush_cnt_o = rst_n ? r_flush_cnt : '0;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus multi-cycle sequences for pipe_ctrl.
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rs1_ren, rs2_ren, load, wen, jump, mstart, done;
  logic [4:0]  rs1, rs2, wa;
  logic [31:0] ja;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, redir, err;
  logic [31:0] raddr, scnt, fcnt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pipe_ctrl #(.PC_WIDTH(32), .MDIV_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_ren_i(rs1_ren), .id_rs2_ren_i(rs2_ren),
    .id_rs1_raddr_i(rs1), .id_rs2_raddr_i(rs2),
    .ex_load_i(load), .ex_rd_wen_i(wen), .ex_rd_waddr_i(wa),
    .ex_jump_i(jump), .ex_jump_addr_i(ja),
    .ex_mdiv_start_i(mstart), .mdiv_done_i(done),
    .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
    .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush),
    .pc_redirect_o(redir), .pc_redirect_addr_o(raddr),
    .mdiv_err_o(err), .stall_cnt_o(scnt), .flush_cnt_o(fcnt)
  );
  // control bundle order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, redirect
  wire [5:0] ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, redir};
  localparam logic [5:0] C_NONE = 6'b000000, C_LU = 6'b110010, C_JMP = 6'b001011, C_MD = 6'b110100;
`ifdef RISCX_PERF_CNT_EN
  localparam logic [31:0] EXP_S = 32'd3, EXP_F = 32'd2;
`else
  localparam logic [31:0] EXP_S = 32'd0, EXP_F = 32'd0;
`endif
  typedef struct {
    logic rs1_ren; logic [4:0] rs1; logic rs2_ren; logic [4:0] rs2;
    logic load; logic wen; logic [4:0] wa; logic jump; logic [31:0] ja;
    logic [5:0] ctl; logic [31:0] ra;
  } vec_t;
  vec_t v[9];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic idle();
    rs1_ren = 0; rs2_ren = 0; rs1 = 0; rs2 = 0; load = 0; wen = 0; wa = 0;
    jump = 0; ja = 0; mstart = 0; done = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_lu();
    load = 1; wen = 1; wa = 5'd5; rs2_ren = 1; rs2 = 5'd5;
  endtask
  initial begin
    v[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'h0, C_NONE, 32'h0};
    v[1] = '{0, 0, 1, 5, 1, 1, 5, 0, 32'h0, C_LU, 32'h0};
    v[2] = '{0, 0, 1, 0, 1, 1, 0, 0, 32'h0, C_NONE, 32'h0};
    v[3] = '{1, 7, 0, 0, 1, 1, 7, 0, 32'h0, C_LU, 32'h0};
    v[4] = '{0, 7, 0, 7, 1, 1, 7, 0, 32'h0, C_NONE, 32'h0};
    v[5] = '{1, 9, 1, 9, 0, 1, 9, 0, 32'h0, C_NONE, 32'h0};
    v[6] = '{1, 9, 1, 9, 1, 0, 9, 0, 32'h0, C_NONE, 32'h0};
    v[7] = '{0, 0, 1, 5, 1, 1, 5, 1, 32'h8000_0040, C_JMP, 32'h8000_0040};
    v[8] = '{1, 3, 0, 0, 0, 0, 0, 1, 32'h0000_0100, C_JMP, 32'h0000_0100};
    idle();
    rst_n = 0; jump = 1; ja = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_ctl%0d", i), {58'd0, ctl}, {58'd0, C_NONE});
      chk($sformatf("rst_misc%0d", i), {err, raddr, scnt[30:0]}, 64'd0);
    end
    tick(); rst_n = 1;
    @(negedge clk);
    chk("rst_release_redir", {26'd0, ctl, raddr}, {26'd0, C_JMP, 32'h1234_5678});
    for (int i = 0; i < 9; i++) begin
      tick();
      idle();
      rs1_ren = v[i].rs1_ren; rs1 = v[i].rs1; rs2_ren = v[i].rs2_ren; rs2 = v[i].rs2;
      load = v[i].load; wen = v[i].wen; wa = v[i].wa; jump = v[i].jump; ja = v[i].ja;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {26'd0, ctl, raddr}, {26'd0, v[i].ctl, v[i].ra});
    end
    tick(); idle(); set_lu();
    @(negedge clk); chk("lu_cycle", {58'd0, ctl}, {58'd0, C_LU});
    tick(); idle();
    @(negedge clk); chk("lu_bubble_next", {58'd0, ctl}, {58'd0, C_NONE});
    tick(); mstart = 1;
    @(negedge clk); chk("md_c0", {58'd0, ctl}, {58'd0, C_MD});
    for (int c = 1; c < 4; c++) begin
      tick(); idle(); jump = (c == 1); ja = 32'hdead_0000; if (c == 2) set_lu();
      @(negedge clk); chk($sformatf("md_c%0d", c), {26'd0, ctl, raddr}, {26'd0, C_MD, 32'h0});
    end
    tick(); idle(); done = 1;
    @(negedge clk); chk("md_c4_release", {57'd0, err, ctl}, {57'd0, 1'b0, C_NONE});
    tick(); idle(); set_lu();
    @(negedge clk); chk("md_c5_run", {57'd0, err, ctl}, {57'd0, 1'b0, C_LU});
    tick(); idle(); mstart = 1;
    @(negedge clk); chk("wd_c0", {58'd0, ctl}, {58'd0, C_MD});
    for (int c = 1; c < 4; c++) begin
      tick(); idle();
      @(negedge clk); chk($sformatf("wd_c%0d", c), {57'd0, err, ctl}, {57'd0, 1'b0, C_MD});
    end
    tick();
    @(negedge clk); chk("wd_c4", {57'd0, err, ctl}, {57'd0, 1'b0, C_NONE});
    tick();
    @(negedge clk); chk("wd_c5_err", {57'd0, err, ctl}, {57'd0, 1'b1, C_NONE});
    tick();
    @(negedge clk); chk("wd_c6", {57'd0, err, ctl}, {57'd0, 1'b0, C_NONE});
    tick(); mstart = 1;
    tick(); idle(); rst_n = 0;
    @(negedge clk); chk("rst_in_wait", {57'd0, err, ctl}, {57'd0, 1'b0, C_NONE});
    tick(); rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); chk($sformatf("post_abort%0d", c), {57'd0, err, ctl}, {57'd0, 1'b0, C_NONE});
      tick();
    end
    rst_n = 0;
    tick(); rst_n = 1;
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 3) set_lu(); else begin jump = 1; ja = 32'h40; end
      tick();
      idle();
      tick();
    end
    @(negedge clk);
    chk("stall_cnt", {32'd0, scnt}, {32'd0, EXP_S});
    chk("flush_cnt", {32'd0, fcnt}, {32'd0, EXP_F});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
